oled_text_buffer: RTL and testbench

//  Character terminal front-end feeding the OLED text renderer.
//  - Accepts a byte stream (UART/CPU) via a valid/ready handshake.
//  - Maintains a NUM_ASCII_COL x NUM_ASCII_ROW character grid with a cursor.
//  - Presents the grid as the flat i_ASCII vector the renderer consumes.
//  - Pulses the renderer's i_START whenever the grid has changed and the renderer is ready.

---
 rtl/oled_pkg.sv | 28 ++
 rtl/oled_refresh_ctrl.sv | 35 +++
 rtl/oled_text_buffer.sv | 151 +++++++++++++++
 tb/tb_oled_text_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED text path: control codes, FSM encoding, grid byte addressing.
// OLED_TEXT_SCROLL_EN adds the SCROLL state; without it overflow wraps to the top row.
package oled_pkg;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

`ifdef OLED_TEXT_SCROLL_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1
  } state_e;
`endif

  // Row 0 col 0 lands in the most significant byte so the grid reads like a string literal.
  function automatic int cell_idx(input int r, input int c, input int ncol, input int ncell);
    return ncell - 1 - (r * ncol + c);
  endfunction

endpackage

// File: rtl/oled_refresh_ctrl.sv
// Refresh request generator: dirty flag plus holdoff counter, o_START is a one-cycle pulse.
// Latency: start is combinational from registered state and oled_ready; a grid change always wins over the clear.
module oled_refresh_ctrl #(
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grid_chg,
  input  logic oled_ready,
  input  logic idle,
  output logic start
);

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [HW-1:0] holdoff_q;
  logic          dirty_q;

  assign start = dirty_q & oled_ready & idle & (holdoff_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dirty_q   <= 1'b1;
      holdoff_q <= '0;
    end else begin
      dirty_q <= grid_chg | (dirty_q & ~start);
      if (start) begin
        holdoff_q <= HW'(HOLDOFF_CYCLES - 1);
      end else if (holdoff_q != '0) begin
        holdoff_q <= holdoff_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_text_buffer.sv
// Character-grid terminal front-end for the OLED text renderer; OLED_TEXT_SCROLL_EN selects scroll vs wrap-to-top.
// Latency: grid updates 1 cycle after accept; backpressure: o_READY low while clearing (one row per cycle) or scrolling.
module oled_text_buffer
  import oled_pkg::*;
#(
  parameter int         NUM_ASCII_COL  = 12,
  parameter int         NUM_ASCII_ROW  = 8,
  parameter int         HOLDOFF_CYCLES = 1000,
  parameter logic [7:0] BLANK_CHAR     = 8'h20
) (
  input  logic                                   i_CLK,
  input  logic                                   i_RST_N,
  input  logic [7:0]                             i_CHAR,
  input  logic                                   i_VALID,
  output logic                                   o_READY,
  input  logic                                   i_OLED_READY,
  output logic                                   o_START,
  output logic [NUM_ASCII_COL*NUM_ASCII_ROW*8-1:0] o_ASCII,
  output logic [$clog2(NUM_ASCII_ROW)-1:0]       o_CURSOR_ROW,
  output logic [$clog2(NUM_ASCII_COL)-1:0]       o_CURSOR_COL
);

  localparam int N    = NUM_ASCII_COL * NUM_ASCII_ROW;
  localparam int RW   = $clog2(NUM_ASCII_ROW);
  localparam int CW   = $clog2(NUM_ASCII_COL);
  localparam int ROWB = NUM_ASCII_COL * 8;
  localparam logic [RW-1:0]   LAST_ROW   = RW'(NUM_ASCII_ROW - 1);
  localparam logic [CW-1:0]   LAST_COL   = CW'(NUM_ASCII_COL - 1);
  localparam logic [N*8-1:0]  BLANK_GRID = {N{BLANK_CHAR}};
  localparam logic [ROWB-1:0] BLANK_ROW  = {NUM_ASCII_COL{BLANK_CHAR}};

  state_e          state_q, state_d;
  logic [N*8-1:0]  grid_q, grid_d;
  logic [RW-1:0]   row_q, row_d, clr_q, clr_d;
  logic [CW-1:0]   col_q, col_d;
  logic            ready_q;
  logic            accept;
  logic            adv_row;
  logic            grid_chg;

  // ready_q is only high in IDLE, so an accepted byte implies IDLE.
  assign accept = i_VALID & ready_q;

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    row_d    = row_q;
    col_d    = col_q;
    clr_d    = clr_q;
    adv_row  = 1'b0;
    grid_chg = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_CHAR >= 8'h20 && i_CHAR <= 8'h7E) begin
            grid_d[cell_idx(int'(row_q), int'(col_q), NUM_ASCII_COL, N)*8 +: 8] = i_CHAR;
            grid_chg = 1'b1;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (i_CHAR == CHR_CR) begin
            col_d = '0;
          end else if (i_CHAR == CHR_LF) begin
            adv_row = 1'b1;
          end else if (i_CHAR == CHR_BS) begin
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
              grid_d[cell_idx(int'(row_q), int'(col_q) - 1, NUM_ASCII_COL, N)*8 +: 8] = BLANK_CHAR;
              grid_chg = 1'b1;
            end
          end else if (i_CHAR == CHR_FF) begin
            state_d = ST_CLEAR;
            clr_d   = '0;
          end
        end
      end
      ST_CLEAR: begin
        grid_d[(N - int'(clr_q) * NUM_ASCII_COL) * 8 - 1 -: ROWB] = BLANK_ROW;
        grid_chg = 1'b1;
        if (clr_q == LAST_ROW) begin
          state_d = ST_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
`ifdef OLED_TEXT_SCROLL_EN
      ST_SCROLL: begin
        grid_d   = {grid_q[N*8-ROWB-1:0], BLANK_ROW};
        grid_chg = 1'b1;
        state_d  = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Cursor moving past the last row: scroll next cycle, or wrap and blank the top row now.
    if (adv_row) begin
      if (row_q == LAST_ROW) begin
`ifdef OLED_TEXT_SCROLL_EN
        state_d = ST_SCROLL;
`else
        row_d    = '0;
        grid_d[N*8-1 -: ROWB] = BLANK_ROW;
        grid_chg = 1'b1;
`endif
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= ST_IDLE;
      grid_q  <= BLANK_GRID;
      row_q   <= '0;
      col_q   <= '0;
      clr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      clr_q   <= clr_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  oled_refresh_ctrl #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_refresh (
    .clk        (i_CLK),
    .rst_n      (i_RST_N),
    .grid_chg   (grid_chg),
    .oled_ready (i_OLED_READY),
    .idle       (ready_q),
    .start      (o_START)
  );

  assign o_READY      = ready_q;
  assign o_ASCII      = grid_q;
  assign o_CURSOR_ROW = row_q;
  assign o_CURSOR_COL = col_q;

endmodule

// File: tb/tb_oled_text_buffer.sv
// Bench for oled_text_buffer: behavioural grid model feeds a scoreboard of expected grid/cursor snapshots.
module tb_oled_text_buffer;
  import oled_pkg::*;

  localparam int COLS = 12;
  localparam int ROWS = 8;
  localparam int HOLD = 100;
  localparam int N    = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     ch = 8'h00;
  logic           valid = 1'b0;
  logic           ready;
  logic           oled_ready = 1'b0;
  logic           start;
  logic [N*8-1:0] ascii;
  logic [2:0]     crow;
  logic [3:0]     ccol;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;

  logic [7:0] m [ROWS][COLS];
  int mr, mc;

  typedef struct {
    logic [N*8-1:0] grid;
    logic [2:0]     row;
    logic [3:0]     col;
  } snap_t;
  snap_t sb [$];

  oled_text_buffer #(
    .NUM_ASCII_COL (COLS),
    .NUM_ASCII_ROW (ROWS),
    .HOLDOFF_CYCLES(HOLD),
    .BLANK_CHAR    (BLANK)
  ) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_CHAR       (ch),
    .i_VALID      (valid),
    .o_READY      (ready),
    .i_OLED_READY (oled_ready),
    .o_START      (start),
    .o_ASCII      (ascii),
    .o_CURSOR_ROW (crow),
    .o_CURSOR_COL (ccol)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start) start_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N*8-1:0] flat();
    logic [N*8-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        f[(N - 1 - (r * COLS + c)) * 8 +: 8] = m[r][c];
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r][c] = BLANK;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_newline();
    if (mr == ROWS - 1) begin
`ifdef OLED_TEXT_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          m[r][c] = m[r+1][c];
      for (int c = 0; c < COLS; c++) m[ROWS-1][c] = BLANK;
`else
      mr = 0;
      for (int c = 0; c < COLS; c++) m[0][c] = BLANK;
`endif
    end else begin
      mr++;
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m[mr][mc] = b;
      mc++;
      if (mc == COLS) begin
        mc = 0;
        model_newline();
      end
    end else if (b == CHR_CR) begin
      mc = 0;
    end else if (b == CHR_LF) begin
      model_newline();
    end else if (b == CHR_BS) begin
      if (mc > 0) begin
        mc--;
        m[mr][mc] = BLANK;
      end
    end else if (b == CHR_FF) begin
      model_clear();
    end
  endtask

  // Drive one byte, push the model's expectation, then pop and compare once the DUT is idle again.
  task automatic send(input logic [7:0] b, output int busy);
    int guard;
    snap_t e;
    guard = 0;
    busy  = 0;
    while (!ready && guard < 50) begin
      tick();
      guard++;
    end
    n_tests++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL send_wait_ready byte=%02h: o_READY stayed %b, required 1", b, ready);
    end
    ch    = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    model_apply(b);
    e.grid = flat();
    e.row  = 3'(mr);
    e.col  = 4'(mc);
    sb.push_back(e);
    while (!ready && busy < 50) begin
      tick();
      busy++;
    end
    n_tests++;
    if (busy >= 50) begin
      n_fail++;
      $display("FAIL send_busy byte=%02h: o_READY never returned (got %b, required 1)", b, ready);
    end
    e = sb.pop_front();
    n_tests++;
    if (ascii !== e.grid) begin
      n_fail++;
      $display("FAIL grid after byte %02h: got %h required %h", b, ascii, e.grid);
    end
    n_tests++;
    if (crow !== e.row || ccol !== e.col) begin
      n_fail++;
      $display("FAIL cursor after byte %02h: got (%0d,%0d) required (%0d,%0d)", b, crow, ccol, e.row, e.col);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base;
    rst_n = 1'b0;
    valid = 1'b0;
    oled_ready = 1'b1;
    repeat (3) tick();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", ready); end
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b required 0", start); end
    n_tests++; if (ascii !== {N{BLANK}}) begin n_fail++; $display("FAIL reset_grid: got %h", ascii); end
    n_tests++; if (crow !== 3'd0 || ccol !== 4'd0) begin n_fail++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", crow, ccol); end
    model_clear();
    base = start_cnt;
    rst_n = 1'b1;
    tick();
    tick();
    n_tests++; if (start_cnt - base != 1) begin n_fail++; $display("FAIL reset_first_start: got %0d pulses required 1", start_cnt - base); end
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_width: got %b required 0", start); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", ready); end
  endtask

  task automatic test_ece532();
    string s;
    logic [7:0] exp6 [6];
    int base, busy;
    s = "ECE532";
    exp6 = '{8'h45, 8'h43, 8'h45, 8'h35, 8'h33, 8'h32};
    base = start_cnt;
    for (int i = 0; i < 6; i++) send(s[i], busy);
    repeat (HOLD + 10) tick();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (ascii[(N - 1 - i) * 8 +: 8] !== exp6[i]) begin
        n_fail++;
        $display("FAIL ece532_byte%0d: got %02h required %02h", i, ascii[(N - 1 - i) * 8 +: 8], exp6[i]);
      end
    end
    n_tests++; if (crow !== 3'd0 || ccol !== 4'd6) begin n_fail++; $display("FAIL ece532_cursor: got (%0d,%0d) required (0,6)", crow, ccol); end
    n_tests++; if (start_cnt - base != 1) begin n_fail++; $display("FAIL ece532_starts: got %0d required 1", start_cnt - base); end
  endtask

  task automatic test_wrap();
    int busy;
    send(CHR_FF, busy);
    n_tests++; if (busy != ROWS) begin n_fail++; $display("FAIL clear_busy: got %0d cycles required %0d", busy, ROWS); end
    repeat (COLS) send(8'h41, busy);
    send(8'h42, busy);
    for (int c = 0; c < COLS; c++) begin
      n_tests++;
      if (ascii[(N - 1 - c) * 8 +: 8] !== 8'h41) begin n_fail++; $display("FAIL wrap_row0_c%0d: got %02h required 41", c, ascii[(N - 1 - c) * 8 +: 8]); end
    end
    n_tests++; if (ascii[(N - 1 - COLS) * 8 +: 8] !== 8'h42) begin n_fail++; $display("FAIL wrap_cell10: got %02h required 42", ascii[(N - 1 - COLS) * 8 +: 8]); end
    n_tests++; if (crow !== 3'd1 || ccol !== 4'd1) begin n_fail++; $display("FAIL wrap_cursor: got (%0d,%0d) required (1,1)", crow, ccol); end
  endtask

  task automatic test_ctrl_codes();
    int busy, base;
    send(CHR_BS, busy);
    n_tests++; if (ascii[(N - 1 - COLS) * 8 +: 8] !== BLANK) begin n_fail++; $display("FAIL bs_blank: got %02h required 20", ascii[(N - 1 - COLS) * 8 +: 8]); end
    send(CHR_BS, busy);
    n_tests++; if (ccol !== 4'd0) begin n_fail++; $display("FAIL bs_col0: got col %0d required 0", ccol); end
    send(8'h78, busy);
    send(8'h79, busy);
    send(CHR_CR, busy);
    send(CHR_LF, busy);
    n_tests++; if (crow !== 3'd2 || ccol !== 4'd0) begin n_fail++; $display("FAIL cr_lf_cursor: got (%0d,%0d) required (2,0)", crow, ccol); end
    send(8'h07, busy);
    send(8'h80, busy);
    send(8'h7F, busy);
    repeat (HOLD + 10) tick();
    base = start_cnt;
    send(8'h01, busy);
    send(8'hFF, busy);
    repeat (HOLD + 10) tick();
    n_tests++; if (start_cnt - base != 0) begin n_fail++; $display("FAIL dropped_no_dirty: got %0d starts required 0", start_cnt - base); end
    send(8'h7E, busy);
    send(8'h20, busy);
    repeat (3) tick();
    n_tests++; if (start_cnt - base != 1) begin n_fail++; $display("FAIL printable_edges_dirty: got %0d starts required 1", start_cnt - base); end
  endtask

  task automatic test_overflow();
    int busy;
    logic [7:0] row1 [COLS];
    send(CHR_FF, busy);
    for (int i = 0; i < N - 1; i++) send(8'(33 + (i % 90)), busy);
    n_tests++; if (crow !== 3'(ROWS - 1) || ccol !== 4'(COLS - 1)) begin n_fail++; $display("FAIL fill_cursor: got (%0d,%0d) required (7,11)", crow, ccol); end
    for (int c = 0; c < COLS; c++) row1[c] = m[1][c];
    send(8'h5A, busy);
`ifdef OLED_TEXT_SCROLL_EN
    n_tests++; if (busy != 1) begin n_fail++; $display("FAIL scroll_busy: got %0d required 1", busy); end
    for (int c = 0; c < COLS; c++) begin
      n_tests++;
      if (ascii[(N - 1 - c) * 8 +: 8] !== row1[c]) begin n_fail++; $display("FAIL scroll_row0_c%0d: got %02h required %02h", c, ascii[(N - 1 - c) * 8 +: 8], row1[c]); end
    end
    n_tests++; if (ascii[COLS*8-1:0] !== {COLS{BLANK}}) begin n_fail++; $display("FAIL scroll_last_row: got %h", ascii[COLS*8-1:0]); end
    n_tests++; if (crow !== 3'(ROWS - 1) || ccol !== 4'd0) begin n_fail++; $display("FAIL scroll_cursor: got (%0d,%0d) required (7,0)", crow, ccol); end
    send(CHR_LF, busy);
    n_tests++; if (busy != 1) begin n_fail++; $display("FAIL lf_scroll_busy: got %0d required 1", busy); end
`else
    n_tests++; if (busy != 0) begin n_fail++; $display("FAIL wrap_busy: got %0d required 0", busy); end
    n_tests++; if (ascii[N*8-1 -: COLS*8] !== {COLS{BLANK}}) begin n_fail++; $display("FAIL wrap_row0_blank: got %h", ascii[N*8-1 -: COLS*8]); end
    n_tests++; if (ascii[7:0] !== 8'h5A) begin n_fail++; $display("FAIL wrap_last_cell: got %02h required 5a", ascii[7:0]); end
    n_tests++; if (crow !== 3'd0 || ccol !== 4'd0) begin n_fail++; $display("FAIL wrap_cursor: got (%0d,%0d) required (0,0)", crow, ccol); end
`endif
  endtask

  task automatic test_clear_hold();
    int busy, base;
    oled_ready = 1'b0;
    send(8'h51, busy);
    base = start_cnt;
    send(CHR_FF, busy);
    n_tests++; if (busy != ROWS) begin n_fail++; $display("FAIL ff_busy: got %0d required %0d", busy, ROWS); end
    n_tests++; if (ascii !== {N{BLANK}}) begin n_fail++; $display("FAIL ff_grid: got %h", ascii); end
    n_tests++; if (crow !== 3'd0 || ccol !== 4'd0) begin n_fail++; $display("FAIL ff_cursor: got (%0d,%0d) required (0,0)", crow, ccol); end
    repeat (HOLD + 10) tick();
    n_tests++; if (start_cnt - base != 0) begin n_fail++; $display("FAIL hold_no_start: got %0d required 0", start_cnt - base); end
    oled_ready = 1'b1;
    tick();
    n_tests++; if (start_cnt - base != 1) begin n_fail++; $display("FAIL hold_release_start: got %0d required 1", start_cnt - base); end
    tick();
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL hold_start_width: got %b required 0", start); end
  endtask

  task automatic test_start_collision();
    int busy, idx;
    oled_ready = 1'b0;
    send(8'h51, busy);
    repeat (HOLD + 5) tick();
    idx = N - 1 - (mr * COLS + mc);
    oled_ready = 1'b1;
    ch = 8'h58;
    valid = 1'b1;
    #1;
    n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL collide_start: got %b required 1", start); end
    tick();
    valid = 1'b0;
    model_apply(8'h58);
    n_tests++; if (ascii[idx*8 +: 8] !== 8'h58) begin n_fail++; $display("FAIL collide_write: got %02h required 58", ascii[idx*8 +: 8]); end
    repeat (HOLD - 2) tick();
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL collide_early: got %b required 0", start); end
    tick();
    n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL collide_second_start: got %b required 1", start); end
  endtask

  task automatic test_reset_mid_clear();
    int busy;
    send(8'h4B, busy);
    send(8'h4C, busy);
    ch = CHR_FF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_clear_busy: got %b required 0", ready); end
    rst_n = 1'b0;
    tick();
    n_tests++; if (ready !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got ready=%b start=%b required 0,0", ready, start); end
    n_tests++; if (ascii !== {N{BLANK}}) begin n_fail++; $display("FAIL midrst_grid: got %h", ascii); end
    n_tests++; if (crow !== 3'd0 || ccol !== 4'd0) begin n_fail++; $display("FAIL midrst_cursor: got (%0d,%0d) required (0,0)", crow, ccol); end
    rst_n = 1'b1;
    model_clear();
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: got %b required 1", ready); end
    send(8'h4D, busy);
  endtask

  initial begin
    test_reset();
    test_ece532();
    test_wrap();
    test_ctrl_codes();
    test_overflow();
    test_clear_hold();
    test_start_collision();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
